// File: rtl/cve2_mem_arbiter_if.sv
// Signal bundle between the two requesters, the shared bus and the memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface cve2_mem_arbiter_if;
  logic        instr_req_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_addr_i;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;

  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  logic        bus_req_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic        bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_err_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o
  );
endinterface

// File: rtl/cve2_mem_arbiter.sv
// Round-robin arbiter sharing one in-order memory bus between instruction and data ports.
// Tracks response ownership in a small FIFO so responses return to the side that was granted.
module cve2_mem_arbiter #(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  cve2_mem_arbiter_if.slave   mem,
  output logic                unexpected_rvalid_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef enum logic { OwnInstr = 1'b0, OwnData = 1'b1 } owner_e;
  typedef enum logic { ArbFree = 1'b0, ArbLocked = 1'b1 } arb_state_e;

  arb_state_e            state_q, state_d;
  owner_e                sel_q, last_q, sel, head;
  owner_e                fifo_q [MaxOutstanding];
  logic [CntW-1:0]       cnt_q;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic                  full, empty, bus_req, grant, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Selection, bus muxing and response routing
  always_comb begin
    state_d = ArbFree;
    sel     = OwnInstr;
    full    = (cnt_q == CntW'(MaxOutstanding));
    empty   = (cnt_q == '0);
    head    = fifo_q[rd_ptr_q];

    if (state_q == ArbLocked) begin
      sel = sel_q;
    end else if (mem.instr_req_i && mem.data_req_i) begin
      sel = (last_q == OwnData) ? OwnInstr : OwnData;
    end else if (mem.data_req_i) begin
      sel = OwnData;
    end

    bus_req = rst_ni & (mem.instr_req_i | mem.data_req_i) & ~full;
    grant   = bus_req & mem.bus_gnt_i;
    pop     = mem.bus_rvalid_i & ~empty;
    if (bus_req && !mem.bus_gnt_i) begin
      state_d = ArbLocked;
    end

    mem.bus_req_o   = bus_req;
    mem.bus_we_o    = (sel == OwnData) ? mem.data_we_i    : 1'b0;
    mem.bus_be_o    = (sel == OwnData) ? mem.data_be_i    : 4'hF;
    mem.bus_addr_o  = (sel == OwnData) ? mem.data_addr_i  : mem.instr_addr_i;
    mem.bus_wdata_o = (sel == OwnData) ? mem.data_wdata_i : 32'h0;

    mem.instr_gnt_o = grant & (sel == OwnInstr);
    mem.data_gnt_o  = grant & (sel == OwnData);

    mem.instr_rvalid_o = pop & (head == OwnInstr);
    mem.data_rvalid_o  = pop & (head == OwnData);
    mem.instr_rdata_o  = (pop && head == OwnInstr) ? mem.bus_rdata_i : 32'h0;
    mem.data_rdata_o   = (pop && head == OwnData)  ? mem.bus_rdata_i : 32'h0;
    mem.instr_err_o    = pop & (head == OwnInstr) & mem.bus_err_i;
    mem.data_err_o     = pop & (head == OwnData)  & mem.bus_err_i;
  end

  // Lock state, round-robin history and owner FIFO
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q             <= ArbFree;
      sel_q               <= OwnInstr;
      last_q              <= OwnData;
      cnt_q               <= '0;
      wr_ptr_q            <= '0;
      rd_ptr_q            <= '0;
      unexpected_rvalid_o <= 1'b0;
      for (int i = 0; i < int'(MaxOutstanding); i++) begin
        fifo_q[i] <= OwnInstr;
      end
    end else begin
      state_q <= state_d;
      sel_q   <= sel;
      if (grant) begin
        last_q           <= sel;
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({grant, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (mem.bus_rvalid_i && empty) begin
        unexpected_rvalid_o <= 1'b1;
      end
    end
  end

endmodule
